// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock-enable generator: sequencer states,
// the default phase accumulator width and the channel index width.
package clk_gen_pkg;

    // Reset sequencer states. HOLD is entered on rst_n only. WAIT_LOCK waits
    // for the synchronised lock flag. COUNT qualifies a stable lock. RUN
    // releases the system and starts the strobes.
    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        COUNT     = 2'd2,
        RUN       = 2'd3
    } state_t;

    // Default phase accumulator width. The strobe rate is f_clkin * inc / 2^ACC_W.
    localparam int ACC_W_DEF = 24;

    // Width of the configuration channel index. It is wide enough for the
    // maximum of eight channels.
    localparam int CH_IDX_W = 3;

endpackage : clk_gen_pkg

// File: rtl/clk_phase_acc.sv
// One fractional-rate strobe channel. The channel holds a programmable
// increment and a phase accumulator. The carry out of each add becomes a
// one-cycle enable pulse. Outside RUN, or on an align request, the
// accumulator is held at zero so that all channels restart from a common
// phase.
module clk_phase_acc
    import clk_gen_pkg::*;
#(
    parameter int              ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] DEF_INC = ACC_W'(32'h0010_0000)
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             run,
    input  logic             align,
    input  logic             we,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             stb
);

    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // The increment register survives lock loss. Only rst_n returns it to the
    // default. A write takes effect on the add that follows the write edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            inc <= DEF_INC;
        end else if (we) begin
            inc <= wr_inc;
        end
    end

    // The sum is one bit wider than the accumulator. Its top bit is the
    // wrap-around carry that marks a strobe.
    always_comb begin
        sum = {1'b0, acc} + {1'b0, inc};
    end

    // The phase accumulator advances only while the system is running.
    // Align or non-RUN forces a zero phase and suppresses the pulse, so a
    // partial or stale pulse never leaks out. The accumulator is not cleared
    // on an increment change, which keeps rate changes glitch-free.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            stb <= 1'b0;
        end else if (!run || align) begin
            acc <= '0;
            stb <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            stb <= sum[ACC_W];
        end
    end

endmodule : clk_phase_acc

// File: rtl/clk_strobe_gen.sv
// Clock-enable generator for the single-clock Z80 system. The block
// synchronises the PLL lock flag and qualifies it for LOCK_CYCLES cycles
// before it releases the system reset. It then generates CHANNELS
// independently programmable fractional-rate enable strobes from phase
// accumulators.
module clk_strobe_gen
    import clk_gen_pkg::*;
#(
    parameter int               CHANNELS    = 3,
    parameter int               ACC_W       = ACC_W_DEF,
    parameter logic [ACC_W-1:0] DEF_INC     = ACC_W'(32'h0010_0000),
    parameter int               LOCK_CYCLES = 1024
) (
    input  logic                clkin,
    input  logic                rst_n,
    input  logic                pll_locked,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    input  logic                cfg_align,
    output logic [CHANNELS-1:0] stb,
    output logic                sys_rst_n,
    output logic                ready
);

    // The lock counter must hold LOCK_CYCLES-1. It is kept at least one bit
    // wide so that a single-cycle qualification still builds.
    localparam int            CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;
    logic             lk_meta;
    logic             lk_s;
    logic             run_next;
    logic             run_q;

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk_s    <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk_s    <= lk_meta;
        end
    end

    // Sequencer state and lock qualification counter.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HOLD;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    // Next-state logic. Any dropout of the synchronised lock restarts the
    // qualification from zero. Lock loss in RUN drops straight back to
    // waiting for lock.
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        case (state)
            HOLD: begin
                state_next    = WAIT_LOCK;
                lock_cnt_next = '0;
            end
            WAIT_LOCK: begin
                lock_cnt_next = '0;
                if (lk_s) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (!lk_s) begin
                    state_next    = WAIT_LOCK;
                    lock_cnt_next = '0;
                end else if (lock_cnt == CNT_LAST) begin
                    state_next    = RUN;
                    lock_cnt_next = '0;
                end else begin
                    lock_cnt_next = lock_cnt + 1'b1;
                end
            end
            RUN: begin
                lock_cnt_next = '0;
                if (!lk_s) begin
                    state_next = WAIT_LOCK;
                end
            end
            default: begin
                state_next    = HOLD;
                lock_cnt_next = '0;
            end
        endcase
    end

    // The channels and the release flag both follow the next state. This
    // makes ready, sys_rst_n and the strobes switch on the same edge as the
    // state register. The first accumulate therefore happens on the edge
    // that enters RUN.
    always_comb begin
        run_next = (state_next == RUN);
    end

    // Registered release flag. It is high exactly while the state is RUN.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= run_next;
        end
    end

    assign ready     = run_q;
    assign sys_rst_n = run_q;

    // One accumulator channel per strobe. The decode compares the full index
    // against each instance number, so an index with no instance behind it
    // writes nothing.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic ch_we;

        assign ch_we = cfg_we && (cfg_ch == CH_IDX_W'(i));

        clk_phase_acc #(
            .ACC_W   (ACC_W),
            .DEF_INC (DEF_INC)
        ) u_acc (
            .clkin  (clkin),
            .rst_n  (rst_n),
            .run    (run_next),
            .align  (cfg_align),
            .we     (ch_we),
            .wr_inc (cfg_inc),
            .stb    (stb[i])
        );
    end

endmodule : clk_strobe_gen

// File: doc/clk_strobe_gen.md
# clk_strobe_gen

Parametrised clock-enable generator for the single-clock Z80 system. It runs entirely in the PLL reference-output domain. It sequences system reset release from the PLL `locked` signal. It then produces N independently programmable fractional-rate enable strobes (CPU, video, peripheral timers) from phase accumulators, which replaces fixed extra PLL outputs for slow clocks.

## Interface
- `CHANNELS`, 3: number of strobe channels (1..8).
- `ACC_W`, 24: phase accumulator width; strobe rate = f_clkin × inc / 2^ACC_W.
- `DEF_INC`, 2^20: reset increment for every channel (1/16 rate; 3.125 MHz at 50 MHz).
- `LOCK_CYCLES`, 1024: consecutive synchronised-locked cycles required before release.
- `clkin` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: asynchronous PLL lock flag, synchronised internally.
- `cfg_we` in 1: one-cycle write strobe for channel increment.
- `cfg_ch` in 3: target channel index.
- `cfg_inc` in ACC_W: new increment; 0 disables the channel.
- `cfg_align` in 1: one-cycle pulse; clears all accumulators together.
- `stb` out CHANNELS: one-cycle enable pulse per channel.
- `sys_rst_n` out 1: sequenced active-low system reset.
- `ready` out 1: high in RUN.

## Operation
- `pll_locked` passes through a 2-FF synchroniser, giving `lk_s`.
- FSM states:
  - HOLD (reset state): moves to WAIT_LOCK on the first clock after reset deasserts.
  - WAIT_LOCK: moves to COUNT when `lk_s`=1.
  - COUNT: increments `lock_cnt`. Any `lk_s`=0 returns to WAIT_LOCK and clears `lock_cnt`. When `lock_cnt` = LOCK_CYCLES-1 with `lk_s`=1, moves to RUN.
  - RUN: `lk_s`=0 moves to WAIT_LOCK.
- `sys_rst_n` and `ready` are registered and equal (state==RUN).
- Per channel, only in RUN:
  - `{carry, acc} <= acc + inc` (ACC_W+1-bit sum), and `stb[i] <= carry`.
  - `inc`=0 never pulses. `inc`=2^ACC_W-1 pulses on all but one cycle in 2^ACC_W.
- Outside RUN: all `acc` are held at 0 and `stb` is 0.
- `cfg_we` with `cfg_ch` < CHANNELS loads `inc[cfg_ch]` at the edge. The new value is used from the following add. `acc` is not cleared, so rate changes are glitch-free. An out-of-range `cfg_ch` is ignored.
- Config writes are accepted in every state, including HOLD exit and COUNT. `inc` registers survive lock loss and reset only via `rst_n` (back to DEF_INC).
- `cfg_align` in RUN forces all `acc` to 0 and `stb` to 0 at the edge.
- `cfg_we` and `cfg_align` in the same cycle: the increment is written and the accumulators are cleared.

## Timing
- Reset values: `stb`=0, `sys_rst_n`=0, `ready`=0, `acc`=0, `inc`=DEF_INC, `lock_cnt`=0, state=HOLD.
- `pll_locked` rising before edge k gives `lk_s`=1 after edge k+1. COUNT is entered at edge k+2. RUN and `sys_rst_n`/`ready`=1 follow LOCK_CYCLES edges later.
- With `inc`=2^(ACC_W-4), the first `stb` is high in the 16th cycle of RUN, then every 16 cycles.
- Lock loss: 2 cycles of synchroniser latency, then `stb`/`ready`/`sys_rst_n` are all 0 from the next edge.
- `rst_n` low mid-operation: all outputs clear immediately (asynchronously). There are no partial pulses.

## Structure
- Package `clk_gen_pkg` holds:
  - the state enum (HOLD, WAIT_LOCK, COUNT, RUN);
  - the ACC_W default;
  - the CH_IDX_W = 3 constant.
- Sub-module `clk_phase_acc`: one channel (inc register, accumulator, carry→strobe, align/hold). It is instantiated CHANNELS times by a generate loop.
- The synchroniser and FSM live in the top level.

## Test plan
- Reset release with `pll_locked`=1, LOCK_CYCLES=16 → `sys_rst_n`/`ready` rise exactly 18 cycles after the first post-reset edge; `stb` stays 0 before that.
- `pll_locked` drops for 1 cycle during COUNT at count 10 → `lock_cnt` restarts and release is delayed by the full count again.
- RUN, ACC_W=24, inc defaults → each `stb` bit pulses every 16 cycles; over 1600 cycles, exactly 100 pulses per channel.
- Write ch1 `inc`=0x555555 → average rate 1/3 (pulse gaps 3/3/3, jitter-free). Write ch2 `inc`=0 → no pulses. Write `cfg_ch`=5 → no change.
- `cfg_align` after differing increments → all `acc`=0 and `stb`=0. Equal-increment channels then pulse in the same cycle. `cfg_we` in the same cycle as `cfg_align` is applied.
- Deassert `pll_locked` in RUN → all outputs 0 within 3 edges and `inc` values are retained. Assert `rst_n`=0 mid-pulse → all outputs clear with no clock, and `inc` returns to DEF_INC.
